// File: rtl/timer_555_prog.sv
// Programmable 555-style timer: astable square wave or monostable one-shot.
// Phase lengths live in shadow registers that can be reloaded while running.
module timer_555_prog #(
  parameter int CNT_W    = 16,
  parameter int DEF_HIGH = 10,
  parameter int DEF_LOW  = 10,
  parameter bit RETRIG   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [CNT_W-1:0] high_time,
  input  logic [CNT_W-1:0] low_time,
  input  logic             trig,
  output logic             out,
  output logic             busy,
  output logic             period_done
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [1:0] M_AST = 2'b01;
  localparam logic [1:0] M_MONO = 2'b10;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_reg;
  logic [CNT_W-1:0] lo_reg;
  logic [CNT_W-1:0] hi_in;
  logic [CNT_W-1:0] lo_in;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic             start;
  logic             abort;
  logic             retrig_hit;

  // Loaded values bypass the shadow regs on the same edge.
  always_comb begin
    hi_in  = (high_time == '0) ? ONE : high_time;
    lo_in  = (low_time == '0) ? ONE : low_time;
    hi_len = load ? hi_in : hi_reg;
    lo_len = load ? lo_in : lo_reg;
    start  = en & ((mode == M_AST) |
                   ((mode == M_MONO) & trig));
    abort  = ~en | (mode != mode_q);
    retrig_hit = RETRIG & (mode_q == M_MONO) & trig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= 2'b00;
      cnt         <= '0;
      hi_reg      <= CNT_W'(DEF_HIGH);
      lo_reg      <= CNT_W'(DEF_LOW);
      out         <= 1'b0;
      busy        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (load) begin
        hi_reg <= hi_in;
        lo_reg <= lo_in;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= HIGH;
            cnt    <= hi_len - ONE;
            mode_q <= mode;
            out    <= 1'b1;
            busy   <= 1'b1;
          end
        end
        HIGH: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
          end else if (retrig_hit) begin
            cnt <= hi_len - ONE;
          end else if (cnt == '0) begin
            out <= 1'b0;
            if (mode_q == M_AST) begin
              state <= LOW;
              cnt   <= lo_len - ONE;
            end else begin
              state       <= IDLE;
              busy        <= 1'b0;
              period_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        LOW: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state       <= HIGH;
            cnt         <= hi_len - ONE;
            out         <= 1'b1;
            period_done <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
